// File: rtl/core_types_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// core_types_pkg : shared core sizing constants and helpers
// Revision: 1.1  added RAS occupancy width and count clamp
// ----------------------------------------------------------------------------
package core_types_pkg;

  // Stack depth must stay a power of two so the pointer wraps for free.
  localparam int RAS_ENTRIES      = 8;
  localparam int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
  localparam int RAS_COUNT_WIDTH  = $clog2(RAS_ENTRIES + 1);
  localparam int RAS_TARGET_WIDTH = 31;

  localparam logic [RAS_COUNT_WIDTH-1:0] RAS_COUNT_MAX = RAS_COUNT_WIDTH'(RAS_ENTRIES);
  localparam logic [RAS_INDEX_WIDTH-1:0] RAS_INDEX_ONE = RAS_INDEX_WIDTH'(1);
  localparam logic [RAS_COUNT_WIDTH-1:0] RAS_COUNT_ONE = RAS_COUNT_WIDTH'(1);

  function automatic logic [RAS_COUNT_WIDTH-1:0] ras_clamp_count(
    input logic [RAS_COUNT_WIDTH-1:0] c
  );
    return (c > RAS_COUNT_MAX) ? RAS_COUNT_MAX : c;
  endfunction

endpackage : core_types_pkg
`default_nettype wire

// File: rtl/ras.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ras : return address stack with checkpoint restore for the fetch predictor
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
module ras
  import core_types_pkg::*;
(
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        link_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] link_target,
  input  logic                        ret_valid,
  output logic [RAS_TARGET_WIDTH-1:0] ret_target,
  output logic                        ret_target_valid,
  output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
  output logic [RAS_COUNT_WIDTH-1:0]  ras_count,
  input  logic                        update_valid,
  input  logic [RAS_INDEX_WIDTH-1:0]  update_ras_index,
  input  logic [RAS_COUNT_WIDTH-1:0]  update_ras_count,
  input  logic                        update_link_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] update_link_target,
  input  logic                        update_ret_valid
);

  logic [RAS_TARGET_WIDTH-1:0] entry_q [RAS_ENTRIES];
  logic [RAS_TARGET_WIDTH-1:0] entry_d [RAS_ENTRIES];
  logic [RAS_INDEX_WIDTH-1:0]  ptr_q, ptr_d;
  logic [RAS_COUNT_WIDTH-1:0]  count_q, count_d;

  logic [RAS_INDEX_WIDTH-1:0]  base_ptr;
  logic [RAS_INDEX_WIDTH-1:0]  base_ptr_dec;
  logic [RAS_COUNT_WIDTH-1:0]  base_count;
  logic                        op_push;
  logic                        op_pop;
  logic [RAS_TARGET_WIDTH-1:0] op_target;
  logic                        wr_en;
  logic [RAS_INDEX_WIDTH-1:0]  wr_idx;
  logic [RAS_INDEX_WIDTH-1:0]  top_idx;

  // A restore replaces the base state and the operation source outright.
  always_comb begin
    base_ptr   = ptr_q;
    base_count = count_q;
    op_push    = link_valid;
    op_pop     = ret_valid;
    op_target  = link_target;
    if (update_valid) begin
      base_ptr   = update_ras_index;
      base_count = ras_clamp_count(update_ras_count);
      op_push    = update_link_valid;
      op_pop     = update_ret_valid;
      op_target  = update_link_target;
    end
  end

  always_comb begin
    base_ptr_dec = base_ptr - RAS_INDEX_ONE;
    ptr_d        = base_ptr;
    count_d      = base_count;
    wr_en        = 1'b0;
    wr_idx       = base_ptr;
    if (op_push && op_pop && (base_count != '0)) begin
      // Coroutine swap: replace top of stack in place.
      wr_en  = 1'b1;
      wr_idx = base_ptr_dec;
    end else if (op_push) begin
      wr_en   = 1'b1;
      ptr_d   = base_ptr + RAS_INDEX_ONE;
      count_d = (base_count == RAS_COUNT_MAX) ? base_count : base_count + RAS_COUNT_ONE;
    end else if (op_pop && (base_count != '0)) begin
      ptr_d   = base_ptr_dec;
      count_d = base_count - RAS_COUNT_ONE;
    end
  end

  always_comb begin
    for (int i = 0; i < RAS_ENTRIES; i++) begin
      entry_d[i] = entry_q[i];
    end
    if (wr_en) begin
      entry_d[wr_idx] = op_target;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign top_idx          = ptr_q - RAS_INDEX_ONE;
  assign ret_target       = entry_q[top_idx];
  assign ret_target_valid = (count_q != '0);
  assign ras_index        = ptr_q;
  assign ras_count        = count_q;

endmodule : ras
`default_nettype wire

// File: tb/tb_ras.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ras : randomized and directed self-checking bench for the return stack
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
module tb_ras;
  import core_types_pkg::*;

  logic                        CLK = 1'b0;
  logic                        nRST;
  logic                        link_valid;
  logic [RAS_TARGET_WIDTH-1:0] link_target;
  logic                        ret_valid;
  logic [RAS_TARGET_WIDTH-1:0] ret_target;
  logic                        ret_target_valid;
  logic [RAS_INDEX_WIDTH-1:0]  ras_index;
  logic [RAS_COUNT_WIDTH-1:0]  ras_count;
  logic                        update_valid;
  logic [RAS_INDEX_WIDTH-1:0]  update_ras_index;
  logic [RAS_COUNT_WIDTH-1:0]  update_ras_count;
  logic                        update_link_valid;
  logic [RAS_TARGET_WIDTH-1:0] update_link_target;
  logic                        update_ret_valid;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: a plain circular array with integer pointer arithmetic.
  logic [RAS_TARGET_WIDTH-1:0] m_entry [RAS_ENTRIES];
  int m_ptr;
  int m_cnt;

  ras dut (
    .CLK                (CLK),
    .nRST               (nRST),
    .link_valid         (link_valid),
    .link_target        (link_target),
    .ret_valid          (ret_valid),
    .ret_target         (ret_target),
    .ret_target_valid   (ret_target_valid),
    .ras_index          (ras_index),
    .ras_count          (ras_count),
    .update_valid       (update_valid),
    .update_ras_index   (update_ras_index),
    .update_ras_count   (update_ras_count),
    .update_link_valid  (update_link_valid),
    .update_link_target (update_link_target),
    .update_ret_valid   (update_ret_valid)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < RAS_ENTRIES; i++) m_entry[i] = '0;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  task automatic model_edge();
    int p, c;
    bit pu, po;
    logic [RAS_TARGET_WIDTH-1:0] t;
    if (update_valid) begin
      p  = int'(update_ras_index);
      c  = int'(update_ras_count);
      pu = update_link_valid;
      po = update_ret_valid;
      t  = update_link_target;
    end else begin
      p  = m_ptr;
      c  = m_cnt;
      pu = link_valid;
      po = ret_valid;
      t  = link_target;
    end
    if (c > RAS_ENTRIES) c = RAS_ENTRIES;
    if (pu && po && c > 0) begin
      m_entry[(p + RAS_ENTRIES - 1) % RAS_ENTRIES] = t;
      m_ptr = p;
      m_cnt = c;
    end else if (pu) begin
      m_entry[p] = t;
      m_ptr = (p + 1) % RAS_ENTRIES;
      m_cnt = (c + 1 > RAS_ENTRIES) ? RAS_ENTRIES : c + 1;
    end else if (po && c > 0) begin
      m_ptr = (p + RAS_ENTRIES - 1) % RAS_ENTRIES;
      m_cnt = c - 1;
    end else begin
      m_ptr = p;
      m_cnt = c;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_tgt"},   32'(ret_target),       32'(m_entry[(m_ptr + RAS_ENTRIES - 1) % RAS_ENTRIES]));
    check({tag, "_vld"},   32'(ret_target_valid), 32'(m_cnt != 0));
    check({tag, "_index"}, 32'(ras_index),        32'(m_ptr));
    check({tag, "_count"}, 32'(ras_count),        32'(m_cnt));
  endtask

  task automatic idle_inputs();
    link_valid         = 1'b0;
    link_target        = '0;
    ret_valid          = 1'b0;
    update_valid       = 1'b0;
    update_ras_index   = '0;
    update_ras_count   = '0;
    update_link_valid  = 1'b0;
    update_link_target = '0;
    update_ret_valid   = 1'b0;
  endtask

  task automatic step(input string tag);
    assert (!update_valid || (int'(update_ras_count) <= RAS_ENTRIES))
      else $error("illegal update_ras_count %0d", update_ras_count);
    @(posedge CLK);
    model_edge();
    #1;
    check_model(tag);
    idle_inputs();
  endtask

  task automatic push(input int t);
    link_valid  = 1'b1;
    link_target = RAS_TARGET_WIDTH'(t);
    step("push");
  endtask

  task automatic pop();
    ret_valid = 1'b1;
    step("pop");
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    idle_inputs();
    nRST = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_model("reset");
    check("reset_tgt_zero", 32'(ret_target), 32'h0);
    @(negedge CLK);
    nRST = 1'b1;

    // Basic push/pop
    push('h100); push('h200); push('h300);
    check("p3_count", 32'(ras_count), 3);
    check("p3_index", 32'(ras_index), 3);
    check("p3_tgt",   32'(ret_target), 32'h300);
    pop();
    check("p3_pop_tgt", 32'(ret_target), 32'h200);

    // Saturation and underflow
    do_reset();
    for (int i = 0; i < 10; i++) push('h10 + i);
    check("sat_count", 32'(ras_count), 8);
    check("sat_index", 32'(ras_index), 2);
    for (int i = 0; i < 8; i++) begin
      check("sat_pop_tgt", 32'(ret_target), 32'('h19 - i));
      pop();
    end
    check("empty_vld", 32'(ret_target_valid), 0);
    pop();
    check("uflow_index", 32'(ras_index), 2);
    check("uflow_count", 32'(ras_count), 0);

    // Coroutine swap
    do_reset();
    push('hA);
    link_valid = 1'b1; link_target = RAS_TARGET_WIDTH'('hB); ret_valid = 1'b1;
    step("swap");
    check("swap_index", 32'(ras_index), 1);
    check("swap_count", 32'(ras_count), 1);
    check("swap_tgt",   32'(ret_target), 32'hB);

    // Checkpoint restore with a return; entry[0] was overwritten by 0x7
    do_reset();
    push('h1); push('h2);
    pop(); pop(); push('h7);
    update_valid = 1'b1; update_ras_index = 2; update_ras_count = 2;
    update_ret_valid = 1'b1; link_valid = 1'b1; link_target = RAS_TARGET_WIDTH'('h99);
    step("restore_ret");
    check("restore_index", 32'(ras_index), 1);
    check("restore_count", 32'(ras_count), 1);
    check("restore_tgt",   32'(ret_target), 32'h7);

    // Restore with a call
    do_reset();
    update_valid = 1'b1; update_ras_index = 5; update_ras_count = 3;
    update_link_valid = 1'b1; update_link_target = RAS_TARGET_WIDTH'('h44);
    step("restore_call");
    check("rcall_index", 32'(ras_index), 6);
    check("rcall_count", 32'(ras_count), 4);
    check("rcall_tgt",   32'(ret_target), 32'h44);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      link_valid  = r[0] | r[1];
      ret_valid   = r[2] & (r[3] | r[4]);
      update_valid = (r[7:5] == 3'b000);
      r = $urandom();
      link_target = r[RAS_TARGET_WIDTH-1:0];
      r = $urandom();
      update_link_target = r[RAS_TARGET_WIDTH-1:0];
      r = $urandom();
      update_link_valid = r[0];
      update_ret_valid  = r[1];
      update_ras_index  = RAS_INDEX_WIDTH'($urandom_range(0, RAS_ENTRIES - 1));
      update_ras_count  = RAS_COUNT_WIDTH'($urandom_range(0, RAS_ENTRIES));
      step("rand");
    end

    // Asynchronous reset between clock edges
    push('h21); push('h22);
    #2;
    nRST = 1'b0;
    #1;
    model_reset();
    check_model("async");
    check("async_count", 32'(ras_count), 0);
    @(negedge CLK);
    nRST = 1'b1;
    push('h55);
    check("post_rst_index", 32'(ras_index), 1);
    check("post_rst_tgt",   32'(ret_target), 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_ras
`default_nettype wire
